hidden_fetch: RTL
=================

HIDDEN_FETCH -- requirements
Module: hidden_fetch

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the program store size in 6-bit instruction words; it must be a power of two, minimum 4.
REQ-002 Parameter AW, default 4, SHALL set the address width, equal to log2(DEPTH).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 load_valid  input  1  SHALL indicate that a program word is offered on load_data.
REQ-006 load_data  input  6  SHALL carry the word: [5:4] opcode, [3:2] reg0 address, [1:0] reg1 address.
REQ-007 load_last  input  1  SHALL mark the offered word as the final program word.
REQ-008 load_ready  output  1  SHALL indicate that a program word can be accepted this cycle.
REQ-009 start  input  1  SHALL request program execution.
REQ-010 redirect_valid  input  1  SHALL request that fetch continue from redirect_addr.
REQ-011 redirect_addr  input  AW  SHALL give the redirect target address.
REQ-012 instr  output  6  SHALL carry the fetched word, wired to CPU io_in[7:2].
REQ-013 instr_addr  output  AW  SHALL give the store address of the word on instr.
REQ-014 instr_valid  output  1  SHALL indicate that instr holds a valid word.
REQ-015 instr_ready  input  1  SHALL indicate that the CPU stage consumes instr this cycle.
REQ-016 state  output  2  SHALL expose the FSM state: IDLE=00, LOAD=01, RUN=10, HALT=11.
REQ-017 halted  output  1  SHALL be high exactly when state is HALT.

Function
REQ-018 A load transfer SHALL occur on a cycle with load_valid and load_ready both high; a fetch transfer SHALL occur on a cycle with instr_valid and instr_ready both high.
REQ-019 load_ready SHALL be high in IDLE, LOAD and HALT, and low in RUN.
REQ-020 A load transfer in IDLE or HALT SHALL:
- write mem[0];
- set the write pointer wptr to 1;
- enter LOAD.
REQ-021 A load transfer in LOAD SHALL write mem[wptr] and increment wptr.
REQ-022 A load transfer with load_last high, or with the write address equal to DEPTH-1, SHALL:
- set program length len = write address + 1;
- return to IDLE.
REQ-023 In IDLE, start with len != 0 SHALL enter RUN with fetch pointer fptr = 0; start with len = 0 SHALL be ignored.
REQ-024 In HALT, start SHALL re-enter RUN with fptr = 0; if load_valid and start are both high, the load SHALL take priority.
REQ-025 start SHALL be ignored in LOAD and RUN.
REQ-026 Timing of the registered output stage:
- instr_valid SHALL rise one cycle after RUN is entered;
- instr and instr_addr SHALL then show mem[fptr] and fptr.
REQ-027 While instr_valid is high and instr_ready is low, instr and instr_addr SHALL hold stable.
REQ-028 On a fetch transfer, fptr SHALL increment and the next word SHALL be presented in the following cycle with no bubble (full throughput).
REQ-029 A fetch transfer of address len-1 SHALL enter HALT, and instr_valid SHALL fall in the next cycle.
REQ-030 A redirect in RUN SHALL behave as follows:
- it SHALL take priority over a simultaneous fetch transfer, and that word SHALL be treated as not consumed;
- instr_valid SHALL be low for exactly one cycle;
- the cycle after that SHALL present mem[redirect_addr].
REQ-031 A redirect with redirect_addr >= len SHALL enter HALT.
REQ-032 redirect_valid SHALL be ignored outside RUN.
REQ-033 instr_valid SHALL be low in IDLE, LOAD and HALT.
REQ-034 Memory contents and len SHALL persist across HALT and IDLE until overwritten by a new load.

Reset
REQ-035 Assertion of rst (low) SHALL, immediately and asynchronously:
- set state to IDLE, with halted = 0 and load_ready = 1;
- clear instr_valid, instr, instr_addr, wptr, fptr and len to 0.
REQ-036 Memory contents SHALL NOT be reset, but len = 0 makes them unreachable until a new load completes.
REQ-037 A reset asserted during LOAD or RUN SHALL abort the operation; the first cycle after deassertion SHALL behave as IDLE.

Configuration
REQ-038 When the macro HIDDEN_FETCH_LOOP_EN is defined, a fetch transfer of address len-1 SHALL set fptr to 0 and remain in RUN with no bubble, instead of entering HALT.
REQ-039 When HIDDEN_FETCH_LOOP_EN is defined, a redirect with redirect_addr >= len SHALL still enter HALT.
REQ-040 When HIDDEN_FETCH_LOOP_EN is undefined, the block SHALL behave as REQ-029.

Verification
REQ-041 Load 3 words 0x21, 0x06, 0x3F (load_last on the third), then start, with instr_ready held at 1 -> instr = 0x21, 0x06, 0x3F on consecutive cycles, instr_addr = 0, 1, 2, then HALT with halted = 1.
REQ-042 Same program with instr_ready low for 4 cycles at word 1 -> instr holds 0x06 with instr_addr = 1 for 4 cycles, and no word is lost or duplicated.
REQ-043 Load 16 words with no load_last -> after the 16th transfer, state returns to IDLE with len = 16, and load_ready falls once RUN is entered.
REQ-044 In RUN, redirect_addr = 1 coincident with a fetch transfer of word 2 -> one cycle with instr_valid = 0, then instr_addr = 1; redirect_addr = 5 with len = 3 -> HALT.
REQ-045 rst pulsed low mid-RUN -> instr_valid = 0 and state = IDLE in the same cycle, and start is ignored afterwards because len = 0.
REQ-046 With HIDDEN_FETCH_LOOP_EN defined and the 3-word program -> instr_addr sequence 0, 1, 2, 0, 1, and halted stays 0.

Source files
------------

// File: rtl/hidden_fetch_if.sv
// hidden_fetch_if -- bundle of the program-load port and the instruction
// fetch port of hidden_fetch.
//
// Handshake rule for both channels: a word moves on a rising clock edge where
// valid and ready are both high. A source holding valid high keeps its
// payload stable until that edge. A sink may raise or lower ready on any
// cycle.
//
// Signals (width):
//   load_valid (1), load_data (6), load_last (1)  -> program word offered
//   load_ready (1)                                 <- word can be accepted
//   start (1)                                      -> run request
//   redirect_valid (1), redirect_addr (AW)         -> fetch redirect
//   instr (6), instr_addr (AW), instr_valid (1)    <- fetched word
//   instr_ready (1)                                -> CPU consumes instr
//
// Modports: slave = hidden_fetch, master = whoever drives it.
interface hidden_fetch_if #(
  parameter int AW = 4
);
  logic          load_valid;
  logic [5:0]    load_data;
  logic          load_last;
  logic          load_ready;
  logic          start;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [5:0]    instr;
  logic [AW-1:0] instr_addr;
  logic          instr_valid;
  logic          instr_ready;

  modport slave (
    input  load_valid, load_data, load_last, start,
    input  redirect_valid, redirect_addr, instr_ready,
    output load_ready, instr, instr_addr, instr_valid
  );

  modport master (
    output load_valid, load_data, load_last, start,
    output redirect_valid, redirect_addr, instr_ready,
    input  load_ready, instr, instr_addr, instr_valid
  );
endinterface

// File: rtl/hidden_fetch.sv
// hidden_fetch -- small program store that is loaded word by word and then
// streamed out to a CPU stage through a registered valid/ready output.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - asynchronous active-low reset
//   bus    - hidden_fetch_if.slave (load, start, redirect, fetch channels)
//   state  - FSM state: IDLE=00, LOAD=01, RUN=10, HALT=11
//   halted - high exactly in HALT
//
// Build option: define HIDDEN_FETCH_LOOP_EN to make the program wrap from its
// last word back to word 0 instead of halting.
//
// Storage is not reset; len returning to 0 makes the old contents unreachable.
module hidden_fetch #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  hidden_fetch_if.slave     bus,
  output logic [1:0]        state,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW-1:0] ADDR_TOP = AW'(DEPTH - 1);

  logic [5:0]    mem [DEPTH];

  state_t        st_q, st_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] fptr_q, fptr_d;
  logic [AW:0]   len_q, len_d;
  logic          iv_q, iv_d;
  logic [5:0]    instr_q, instr_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  logic          load_fire;
  logic          fetch_fire;
  logic          fetch_last;
  logic [AW-1:0] fptr_inc;

  assign bus.load_ready  = (st_q != RUN);
  assign bus.instr_valid = iv_q;
  assign bus.instr       = instr_q;
  assign bus.instr_addr  = iaddr_q;
  assign state           = st_q;
  assign halted          = (st_q == HALT);

  assign load_fire  = bus.load_valid && (st_q != RUN);
  assign fetch_fire = iv_q && bus.instr_ready;
  // fptr always equals instr_addr while a word is presented.
  assign fetch_last = (({1'b0, fptr_q} + LEN_ONE) == len_q);
  assign fptr_inc   = fptr_q + ADDR_ONE;

  always_comb begin
    st_d      = st_q;
    wptr_d    = wptr_q;
    fptr_d    = fptr_q;
    len_d     = len_q;
    iv_d      = iv_q;
    instr_d   = instr_q;
    iaddr_d   = iaddr_q;
    mem_we    = 1'b0;
    mem_waddr = wptr_q;

    case (st_q)
      IDLE, HALT: begin
        iv_d = 1'b0;
        // A load wins over a simultaneous start.
        if (load_fire) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wptr_d    = ADDR_ONE;
          st_d      = LOAD;
          if (bus.load_last) begin
            len_d = LEN_ONE;
            st_d  = IDLE;
          end
        end else if (bus.start && (st_q == HALT || len_q != '0)) begin
          st_d   = RUN;
          fptr_d = '0;
        end
      end

      LOAD: begin
        if (load_fire) begin
          mem_we    = 1'b1;
          mem_waddr = wptr_q;
          wptr_d    = wptr_q + ADDR_ONE;
          if (bus.load_last || wptr_q == ADDR_TOP) begin
            len_d = {1'b0, wptr_q} + LEN_ONE;
            st_d  = IDLE;
          end
        end
      end

      RUN: begin
        if (bus.redirect_valid) begin
          // The word on the output is dropped even if it was being taken.
          iv_d = 1'b0;
          if ({1'b0, bus.redirect_addr} >= len_q) st_d = HALT;
          else fptr_d = bus.redirect_addr;
        end else if (!iv_q) begin
          // Fill the output register after RUN entry or a redirect bubble.
          iv_d    = 1'b1;
          instr_d = mem[fptr_q];
          iaddr_d = fptr_q;
        end else if (fetch_fire) begin
          if (fetch_last) begin
`ifdef HIDDEN_FETCH_LOOP_EN
            fptr_d  = '0;
            instr_d = mem[0];
            iaddr_d = '0;
`else
            iv_d = 1'b0;
            st_d = HALT;
`endif
          end else begin
            fptr_d  = fptr_inc;
            instr_d = mem[fptr_inc];
            iaddr_d = fptr_inc;
          end
        end
      end

      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= IDLE;
      wptr_q  <= '0;
      fptr_q  <= '0;
      len_q   <= '0;
      iv_q    <= 1'b0;
      instr_q <= '0;
      iaddr_q <= '0;
    end else begin
      st_q    <= st_d;
      wptr_q  <= wptr_d;
      fptr_q  <= fptr_d;
      len_q   <= len_d;
      iv_q    <= iv_d;
      instr_q <= instr_d;
      iaddr_q <= iaddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bus.load_data;
  end

endmodule
